// File: rtl/oven_setpoint_entry.sv
// rtl/oven_setpoint_entry.sv - oven setpoint entry front end (optional AUTO_REPEAT_EN auto-repeat)
// Synchronises/debounces buttons, edits temperature then time, offers the pair over valid/ack.
module oven_setpoint_entry #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int TEMP_MIN        = 150,
   parameter int TEMP_MAX        = 500,
   parameter int TEMP_STEP       = 25,
   parameter int TEMP_DEFAULT    = 350,
   parameter int TIME_MIN        = 30,
   parameter int TIME_MAX        = 7200,
   parameter int TIME_STEP       = 30,
   parameter int TIME_DEFAULT    = 1800,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_RATE     = 5000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        power,
   input  logic        btn_up,
   input  logic        btn_down,
   input  logic        btn_next,
   output logic [8:0]  temp_set,
   output logic [16:0] time_set,
   output logic [1:0]  field_sel,
   output logic        set_valid,
   input  logic        set_ack
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_EDIT_TEMP = 3'd1;
   localparam logic [2:0] S_EDIT_TIME = 3'd2;
   localparam logic [2:0] S_OFFER     = 3'd3;
   localparam logic [2:0] S_DONE      = 3'd4;

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

   localparam logic [8:0]  T_MIN  = 9'(TEMP_MIN);
   localparam logic [8:0]  T_MAX  = 9'(TEMP_MAX);
   localparam logic [8:0]  T_STEP = 9'(TEMP_STEP);
   localparam logic [8:0]  T_DEF  = 9'(TEMP_DEFAULT);
   localparam logic [16:0] M_MIN  = 17'(TIME_MIN);
   localparam logic [16:0] M_MAX  = 17'(TIME_MAX);
   localparam logic [16:0] M_STEP = 17'(TIME_STEP);
   localparam logic [16:0] M_DEF  = 17'(TIME_DEFAULT);

   logic [3:0]    sync1_q, sync2_q;
   logic [DW-1:0] db_cnt_q [3];
   logic [2:0]    db_lvl_q, db_prev_q;
   logic [2:0]    state_q, state_d;
   logic [8:0]    temp_q, temp_d, temp_up, temp_dn;
   logic [16:0]   time_q, time_d, time_up, time_dn;
   logic [2:0]    press;
   logic          pwr, up_p, down_p, next_p, inc_req, dec_req;

   // Bit order of the synchroniser: {power, next, down, up}
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         db_lvl_q  <= '0;
         db_prev_q <= '0;
         for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
      end else begin
         sync1_q   <= {power, btn_next, btn_down, btn_up};
         sync2_q   <= sync1_q;
         db_prev_q <= db_lvl_q;
         for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] != db_lvl_q[i]) begin
               if (db_cnt_q[i] == DB_LAST) begin
                  db_lvl_q[i] <= sync2_q[i];
                  db_cnt_q[i] <= '0;
               end else begin
                  db_cnt_q[i] <= db_cnt_q[i] + DW'(1);
               end
            end else begin
               db_cnt_q[i] <= '0;
            end
         end
      end
   end

   assign press  = db_lvl_q & ~db_prev_q;
   assign up_p   = press[0];
   assign down_p = press[1];
   assign next_p = press[2];
   assign pwr    = sync2_q[3];

   // Saturating steps compare against the bound before adding/subtracting so nothing wraps.
   assign temp_up = (temp_q >= T_MAX - T_STEP) ? T_MAX : temp_q + T_STEP;
   assign temp_dn = (temp_q <= T_MIN + T_STEP) ? T_MIN : temp_q - T_STEP;
   assign time_up = (time_q >= M_MAX - M_STEP) ? M_MAX : time_q + M_STEP;
   assign time_dn = (time_q <= M_MIN + M_STEP) ? M_MIN : time_q - M_STEP;

`ifdef AUTO_REPEAT_EN
   localparam int RW = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
   logic [RW-1:0] rpt_cnt_q;
   logic          rpt_active_q, rpt_first_q, rpt_fire, single_lvl, in_edit;

   assign single_lvl = db_lvl_q[0] ^ db_lvl_q[1];
   assign in_edit    = (state_q == S_EDIT_TEMP) || (state_q == S_EDIT_TIME);
   assign rpt_fire   = rpt_active_q && single_lvl && in_edit &&
                       (rpt_first_q ? (rpt_cnt_q == RW'(REPEAT_DELAY - 1))
                                    : (rpt_cnt_q == RW'(REPEAT_RATE - 1)));
   assign inc_req    = (up_p & ~down_p) | (rpt_fire & db_lvl_q[0]);
   assign dec_req    = (down_p & ~up_p) | (rpt_fire & db_lvl_q[1]);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rpt_active_q <= 1'b0;
         rpt_first_q  <= 1'b0;
         rpt_cnt_q    <= '0;
      end else if ((up_p ^ down_p) && in_edit && !next_p && pwr) begin
         rpt_active_q <= 1'b1;
         rpt_first_q  <= 1'b1;
         rpt_cnt_q    <= '0;
      end else if (!single_lvl || next_p || !in_edit || state_d != state_q) begin
         rpt_active_q <= 1'b0;
         rpt_cnt_q    <= '0;
      end else if (rpt_fire) begin
         rpt_first_q  <= 1'b0;
         rpt_cnt_q    <= '0;
      end else if (rpt_active_q) begin
         rpt_cnt_q    <= rpt_cnt_q + RW'(1);
      end
   end
`else
   assign inc_req = up_p & ~down_p;
   assign dec_req = down_p & ~up_p;
`endif

   always_comb begin
      state_d = state_q;
      temp_d  = temp_q;
      time_d  = time_q;
      if (!pwr) begin
         state_d = S_IDLE;
         temp_d  = '0;
         time_d  = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               temp_d  = T_DEF;
               time_d  = M_DEF;
               state_d = S_EDIT_TEMP;
            end
            S_EDIT_TEMP: begin
               if (next_p)       state_d = S_EDIT_TIME;
               else if (inc_req) temp_d  = temp_up;
               else if (dec_req) temp_d  = temp_dn;
            end
            S_EDIT_TIME: begin
               if (next_p)       state_d = S_OFFER;
               else if (inc_req) time_d  = time_up;
               else if (dec_req) time_d  = time_dn;
            end
            S_OFFER: if (set_ack) state_d = S_DONE;
            S_DONE:  if (next_p)  state_d = S_EDIT_TEMP;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         temp_q  <= '0;
         time_q  <= '0;
      end else begin
         state_q <= state_d;
         temp_q  <= temp_d;
         time_q  <= time_d;
      end
   end

   always_comb begin
      field_sel = 2'b00;
      case (state_q)
         S_EDIT_TEMP:     field_sel = 2'b01;
         S_EDIT_TIME:     field_sel = 2'b10;
         S_OFFER, S_DONE: field_sel = 2'b11;
         default:         field_sel = 2'b00;
      endcase
   end

   assign temp_set  = temp_q;
   assign time_set  = time_q;
   assign set_valid = (state_q == S_OFFER);

endmodule

// File: tb/tb_oven_setpoint_entry.sv
// tb/tb_oven_setpoint_entry.sv - directed self-checking bench for oven_setpoint_entry
// Debounce 4, repeat delay 20, repeat rate 8; expectations follow AUTO_REPEAT_EN when defined.
module tb_oven_setpoint_entry;

   logic        clk = 1'b0;
   logic        rst_n, power, btn_up, btn_down, btn_next, set_ack;
   logic [8:0]  temp_set;
   logic [16:0] time_set;
   logic [1:0]  field_sel;
   logic        set_valid;
   int          n_checks = 0;
   int          n_pass = 0;

   oven_setpoint_entry #(
      .DEBOUNCE_CYCLES(4),
      .REPEAT_DELAY   (20),
      .REPEAT_RATE    (8)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .power    (power),
      .btn_up   (btn_up),
      .btn_down (btn_down),
      .btn_next (btn_next),
      .temp_set (temp_set),
      .time_set (time_set),
      .field_sel(field_sel),
      .set_valid(set_valid),
      .set_ack  (set_ack)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // bits: {next, down, up}; raw high 10 cycles then low long enough to debounce the release
   task automatic press(input logic [2:0] b);
      {btn_next, btn_down, btn_up} = b;
      tick(10);
      {btn_next, btn_down, btn_up} = 3'b000;
      tick(10);
   endtask

   initial begin
      rst_n = 1'b0; power = 1'b1; btn_up = 1'b0; btn_down = 1'b0; btn_next = 1'b0; set_ack = 1'b0;
      tick(3);
      check("rst_temp", temp_set, 0);
      check("rst_time", time_set, 0);
      check("rst_field", field_sel, 0);
      check("rst_valid", set_valid, 0);
      rst_n = 1'b1;
      tick(2);
      check("idle_after_sync", field_sel, 0);
      tick(1);
      check("entry_field", field_sel, 1);
      check("entry_temp", temp_set, 350);
      check("entry_time", time_set, 1800);

      btn_up = 1'b1;
      tick(6);
      check("lat_before", temp_set, 350);
      tick(1);
      check("lat_at7", temp_set, 375);
      tick(3);
      btn_up = 1'b0;
      tick(10);
      btn_up = 1'b1;
      tick(3);
      btn_up = 1'b0;
      tick(10);
      check("glitch", temp_set, 375);

      for (int i = 0; i < 5; i++) press(3'b001);
      check("sat_reach", temp_set, 500);
      press(3'b001);
      check("sat_hold", temp_set, 500);
      for (int i = 0; i < 15; i++) press(3'b010);
      check("min_hold", temp_set, 150);
      press(3'b011);
      check("up_down_same", temp_set, 150);
      press(3'b001);
      check("up_after_both", temp_set, 175);

      set_ack = 1'b1;
      tick(1);
      set_ack = 1'b0;
      check("ack_ignored", field_sel, 1);

      press(3'b100);
      check("to_time", field_sel, 2);
      press(3'b001);
      check("time_up", time_set, 1830);
      press(3'b010);
      press(3'b010);
      check("time_down", time_set, 1770);
      press(3'b101);
      check("next_wins_time", time_set, 1770);
      check("offer_field", field_sel, 3);
      check("offer_valid", set_valid, 1);
      press(3'b001);
      press(3'b010);
      check("offer_temp_held", temp_set, 175);
      check("offer_time_held", time_set, 1770);
      check("offer_still_valid", set_valid, 1);
      set_ack = 1'b1;
      tick(1);
      set_ack = 1'b0;
      check("ack_valid_drop", set_valid, 0);
      check("done_field", field_sel, 3);
      press(3'b100);
      check("reedit_field", field_sel, 1);
      check("reedit_temp", temp_set, 175);

      press(3'b100);
      power = 1'b0;
      tick(2);
      check("pwr_sync_lag", field_sel, 2);
      tick(1);
      check("pwr_field", field_sel, 0);
      check("pwr_temp", temp_set, 0);
      check("pwr_time", time_set, 0);
      check("pwr_valid", set_valid, 0);
      power = 1'b1;
      tick(3);
      check("repower_temp", temp_set, 350);

      btn_up = 1'b1;
      tick(7);
      check("rpt_first", temp_set, 375);
      tick(19);
      check("rpt_before_delay", temp_set, 375);
      tick(1);
`ifdef AUTO_REPEAT_EN
      check("rpt_delay", temp_set, 400);
`else
      check("rpt_delay", temp_set, 375);
`endif
      tick(7);
`ifdef AUTO_REPEAT_EN
      check("rpt_before_rate", temp_set, 400);
`else
      check("rpt_before_rate", temp_set, 375);
`endif
      tick(1);
`ifdef AUTO_REPEAT_EN
      check("rpt_rate", temp_set, 425);
`else
      check("rpt_rate", temp_set, 375);
`endif
      btn_up = 1'b0;
      tick(12);
`ifndef AUTO_REPEAT_EN
      check("rpt_single_step", temp_set, 375);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
